bg_scroller: RTL and testbench

- Multi-slot background-object scroller: up to NUM_OBJ independent decorative objects (clouds, far-ground items), each spawning at the right edge and moving left one step per game tick until it leaves the screen.
- Generalises the single-object background mover. Adds per-slot active flags, a latched object kind, a selectable scroll speed, a randomised spawn gap, a pause control and a synchronous clear.
- Sits between the LFSR/RNG and the background renderer; updates only on the 20 Hz game_tick.

---
 rtl/bg_scroller.sv | 106 ++++++++++
 tb/tb_bg_scroller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bg_scroller.sv
// Multi-slot background-object scroller: objects spawn at the right edge, move left one
// step per qualifying game tick and despawn once they would cross the left edge.
module bg_scroller #(
  parameter int unsigned CONV    = 0,
  parameter int unsigned NUM_OBJ = 3,
  parameter int unsigned MIN_GAP = 4,
  localparam int unsigned POS_W  = 10 - CONV
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     game_tick,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [1:0]               speed,
  input  logic [7:0]               rng,
  output logic [NUM_OBJ*POS_W-1:0] obj_pos,
  output logic [NUM_OBJ-1:0]       obj_active,
  output logic [NUM_OBJ*2-1:0]     obj_kind
);

  localparam logic [4:0] GapLo = 5'(MIN_GAP);
  localparam logic [4:0] GapHi = 5'(2 * MIN_GAP);

  logic [POS_W-1:0]   pos_q  [NUM_OBJ];
  logic [POS_W-1:0]   pos_d  [NUM_OBJ];
  logic [1:0]         kind_q [NUM_OBJ];
  logic [1:0]         kind_d [NUM_OBJ];
  logic [NUM_OBJ-1:0] active_q, active_d;
  logic [4:0]         gap_q, gap_d;
  logic [POS_W-1:0]   step;
  logic [POS_W-1:0]   spawn_pos;
  logic               spawned;

  always_comb begin
    pos_d     = pos_q;
    kind_d    = kind_q;
    active_d  = active_q;
    gap_d     = gap_q;
    spawned   = 1'b0;
    step      = POS_W'({1'b0, speed}) + POS_W'(1);
    spawn_pos = {{(5 - CONV){1'b1}}, rng[6:2]};

    if (clear) begin
      for (int unsigned i = 0; i < NUM_OBJ; i++) begin
        pos_d[i]  = '0;
        kind_d[i] = '0;
      end
      active_d = '0;
      gap_d    = GapLo;
    end else if (game_tick && enable) begin
      for (int unsigned i = 0; i < NUM_OBJ; i++) begin
        if (active_q[i]) begin
          if (pos_q[i] >= step) begin
            pos_d[i] = pos_q[i] - step;
          end else begin
            pos_d[i]    = '0;
            kind_d[i]   = '0;
            active_d[i] = 1'b0;
          end
        end
      end

      // Eligibility uses the pre-tick flags, so a slot despawning now cannot respawn now.
      if (gap_q != 5'd0) begin
        gap_d = gap_q - 5'd1;
      end else begin
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
          if (!active_q[i] && !spawned) begin
            spawned     = 1'b1;
            pos_d[i]    = spawn_pos;
            kind_d[i]   = rng[1:0];
            active_d[i] = 1'b1;
            gap_d       = rng[7] ? GapHi : GapLo;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_OBJ; i++) begin
        pos_q[i]  <= '0;
        kind_q[i] <= '0;
      end
      active_q <= '0;
      gap_q    <= '0;
    end else begin
      pos_q    <= pos_d;
      kind_q   <= kind_d;
      active_q <= active_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    obj_pos  = '0;
    obj_kind = '0;
    for (int unsigned i = 0; i < NUM_OBJ; i++) begin
      obj_pos[i*POS_W +: POS_W] = pos_q[i];
      obj_kind[i*2 +: 2]        = kind_q[i];
    end
    obj_active = active_q;
  end

endmodule

// File: tb/tb_bg_scroller.sv
// Scoreboard bench for bg_scroller: the driver pushes model-predicted outputs per cycle,
// a monitor pops and compares them just after each clock edge.
module tb_bg_scroller;

  localparam int unsigned CONV    = 0;
  localparam int unsigned NUM_OBJ = 3;
  localparam int unsigned MIN_GAP = 4;
  localparam int unsigned POS_W   = 10 - CONV;

  typedef struct packed {
    logic [NUM_OBJ*POS_W-1:0] pos;
    logic [NUM_OBJ-1:0]       act;
    logic [NUM_OBJ*2-1:0]     kind;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     game_tick = 1'b0;
  logic                     enable = 1'b0;
  logic                     clear = 1'b0;
  logic [1:0]               speed = 2'd0;
  logic [7:0]               rng = 8'd0;
  logic [NUM_OBJ*POS_W-1:0] obj_pos;
  logic [NUM_OBJ-1:0]       obj_active;
  logic [NUM_OBJ*2-1:0]     obj_kind;

  bg_scroller #(
    .CONV    (CONV),
    .NUM_OBJ (NUM_OBJ),
    .MIN_GAP (MIN_GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .game_tick  (game_tick),
    .enable     (enable),
    .clear      (clear),
    .speed      (speed),
    .rng        (rng),
    .obj_pos    (obj_pos),
    .obj_active (obj_active),
    .obj_kind   (obj_kind)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers describing each slot on screen.
  int m_pos  [NUM_OBJ];
  int m_kind [NUM_OBJ];
  int m_act  [NUM_OBJ];
  int m_gap;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic exp_t model_pack();
    exp_t e;
    e = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      e.pos[i*POS_W +: POS_W] = POS_W'(m_pos[i]);
      e.kind[i*2 +: 2]        = 2'(m_kind[i]);
      e.act[i]                = (m_act[i] != 0);
    end
    return e;
  endfunction

  task automatic model_step(input bit r_n, input bit clr, input bit tick, input bit en,
                            input int spd, input int r);
    int was_act [NUM_OBJ];
    int step;
    bit done;
    if (!r_n) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        m_pos[i] = 0; m_kind[i] = 0; m_act[i] = 0;
      end
      m_gap = 0;
    end else if (clr) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        m_pos[i] = 0; m_kind[i] = 0; m_act[i] = 0;
      end
      m_gap = MIN_GAP;
    end else if (tick && en) begin
      step = spd + 1;
      for (int i = 0; i < NUM_OBJ; i++) was_act[i] = m_act[i];
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (m_act[i] != 0) begin
          if (m_pos[i] >= step) m_pos[i] = m_pos[i] - step;
          else begin
            m_pos[i] = 0; m_kind[i] = 0; m_act[i] = 0;
          end
        end
      end
      if (m_gap > 0) m_gap = m_gap - 1;
      else begin
        done = 1'b0;
        for (int i = 0; i < NUM_OBJ; i++) begin
          if (!done && was_act[i] == 0) begin
            done      = 1'b1;
            m_pos[i]  = (((1 << (5 - CONV)) - 1) * 32) + ((r >> 2) & 31);
            m_kind[i] = r & 3;
            m_act[i]  = 1;
            m_gap     = MIN_GAP * (1 + ((r >> 7) & 1));
          end
        end
      end
    end
  endtask

  task automatic cycle(input bit r_n, input bit clr, input bit tick, input bit en,
                       input int spd, input int r);
    @(negedge clk);
    rst_n     = r_n;
    clear     = clr;
    game_tick = tick;
    enable    = en;
    speed     = 2'(spd);
    rng       = 8'(r);
    model_step(r_n, clr, tick, en, spd, r);
    exp_q.push_back(model_pack());
  endtask

  // Monitor: every clock edge the DUT presents a fresh registered state.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obj_pos !== e.pos) begin
        miscompares++;
        $display("FAIL obj_pos t=%0t got %h expected %h", $time, obj_pos, e.pos);
      end
      vectors++;
      if (obj_active !== e.act) begin
        miscompares++;
        $display("FAIL obj_active t=%0t got %b expected %b", $time, obj_active, e.act);
      end
      vectors++;
      if (obj_kind !== e.kind) begin
        miscompares++;
        $display("FAIL obj_kind t=%0t got %h expected %h", $time, obj_kind, e.kind);
      end
    end
  end

  initial begin
    int spd;
    // Reset, then the directed opening: spawn at 1023 kind 3, four moves, then a 992 spawn.
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 8'h7F);
    cycle(1, 0, 0, 1, 0, 8'h7F);
    cycle(1, 0, 1, 1, 0, 8'h7F);
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 1, 0, 8'h7F);
    cycle(1, 0, 1, 1, 0, 8'h80);
    cycle(1, 0, 0, 1, 0, 8'h80);

    // Pause: ticks with enable low must not change anything.
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, 0, 3, $urandom);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 1, 0, $urandom);

    // Clear together with a tick wins; next spawn MIN_GAP+1 ticks later.
    cycle(1, 1, 1, 1, 0, 8'h00);
    for (int i = 0; i < MIN_GAP + 2; i++) cycle(1, 0, 1, 1, 1, $urandom);

    // Fast scroll with back-to-back ticks to exercise full slots and despawn/respawn.
    for (int i = 0; i < 800; i++) cycle(1, 0, 1, 1, 3, $urandom);

    // Randomised play with occasional pause, clear and reset.
    spd = 0;
    for (int i = 0; i < 12000; i++) begin
      if (i % 300 == 0) spd = int'($urandom_range(0, 3));
      cycle(($urandom % 3000) != 0, ($urandom % 700) == 0, ($urandom % 4) != 0,
            ($urandom % 16) != 0, spd, $urandom);
    end

    // Reset mid-game with everything else active.
    cycle(0, 1, 1, 1, 3, 8'hFF);
    cycle(1, 0, 1, 1, 2, 8'h7F);

    @(negedge clk);
    game_tick = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
